// File: rtl/regfile_rename2_if.sv
// Issue / ROB-query / commit / operand bus for the 2-wide rename register file.
interface regfile_rename2_if #(
  parameter int XLEN    = 32,
  parameter int REG_LOG = 5,
  parameter int ROB_LOG = 3
);
  localparam int TAGW = ROB_LOG + 1;

  logic                   rdy;
  logic                   flush;
  logic [1:0]             iss_valid;
  logic [1:0]             iss_rs1_hv;
  logic [1:0]             iss_rs2_hv;
  logic [1:0]             iss_rd_hv;
  logic [2*REG_LOG-1:0]   iss_rs1;
  logic [2*REG_LOG-1:0]   iss_rs2;
  logic [2*REG_LOG-1:0]   iss_rd;
  logic [2*TAGW-1:0]      iss_tag;
  logic [4*TAGW-1:0]      rob_q_tag;
  logic [3:0]             rob_q_rdy;
  logic [4*XLEN-1:0]      rob_q_val;
  logic                   cmt_valid;
  logic [REG_LOG-1:0]     cmt_rd;
  logic [TAGW-1:0]        cmt_tag;
  logic [XLEN-1:0]        cmt_val;
  logic [4*XLEN-1:0]      opr_v;
  logic [4*TAGW-1:0]      opr_q;
  logic [REG_LOG:0]       busy_cnt;

  modport master (
    output rdy, flush, iss_valid, iss_rs1_hv, iss_rs2_hv, iss_rd_hv,
           iss_rs1, iss_rs2, iss_rd, iss_tag, rob_q_rdy, rob_q_val,
           cmt_valid, cmt_rd, cmt_tag, cmt_val,
    input  rob_q_tag, opr_v, opr_q, busy_cnt
  );

  modport slave (
    input  rdy, flush, iss_valid, iss_rs1_hv, iss_rs2_hv, iss_rd_hv,
           iss_rs1, iss_rs2, iss_rd, iss_tag, rob_q_rdy, rob_q_val,
           cmt_valid, cmt_rd, cmt_tag, cmt_val,
    output rob_q_tag, opr_v, opr_q, busy_cnt
  );
endinterface

// File: rtl/regfile_rename2.sv
// 2-wide architectural register file with rename (busy/tag) tracking.
// Operands are resolved combinationally from intra-group bypass, the
// committing result, the ROB, or the register file itself.
module regfile_rename2 #(
  parameter int XLEN    = 32,
  parameter int REG_LOG = 5,
  parameter int ROB_LOG = 3
) (
  input logic               clk,
  input logic               rst,
  regfile_rename2_if.slave  bus
);
  localparam int NREG = 1 << REG_LOG;
  localparam int TAGW = ROB_LOG + 1;

  logic [NREG-1:0][XLEN-1:0] r_data;
  logic [NREG-1:0]           r_busy;
  logic [NREG-1:0][TAGW-1:0] r_tag;
  logic [REG_LOG:0]          r_busy_cnt;

  logic [NREG-1:0]           w_busy_nxt;
  logic [NREG-1:0][TAGW-1:0] w_tag_nxt;
  logic [REG_LOG:0]          w_cnt_nxt;

  logic [3:0][REG_LOG-1:0]   w_src;
  logic [3:0]                w_hv;
  logic [3:0]                w_sv;
  logic [3:0][XLEN-1:0]      w_opr_v;
  logic [3:0][TAGW-1:0]      w_opr_q;
  logic [3:0][TAGW-1:0]      w_qtag;
  logic [1:0][REG_LOG-1:0]   w_rd;
  logic [1:0]                w_ren;

  assign bus.rob_q_tag = w_qtag;
  assign bus.opr_v     = w_opr_v;
  assign bus.opr_q     = w_opr_q;
  assign bus.busy_cnt  = r_busy_cnt;

  // Unpack per-operand source fields; operand k = {slot k/2, rs1 when k even}.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_rd[s]  = bus.iss_rd[s*REG_LOG +: REG_LOG];
      w_ren[s] = bus.iss_valid[s] & bus.iss_rd_hv[s] & (w_rd[s] != '0);
    end
    for (int k = 0; k < 4; k++) begin
      w_sv[k]  = bus.iss_valid[k/2];
      w_src[k] = (k % 2 == 0) ? bus.iss_rs1[(k/2)*REG_LOG +: REG_LOG]
                              : bus.iss_rs2[(k/2)*REG_LOG +: REG_LOG];
      w_hv[k]  = (k % 2 == 0) ? bus.iss_rs1_hv[k/2] : bus.iss_rs2_hv[k/2];
    end
  end

  // Operand resolution, first match wins; slot1 sees slot0's rename first.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_qtag[k]  = r_tag[w_src[k]];
      w_opr_v[k] = '0;
      w_opr_q[k] = '0;
      if (!w_sv[k] || !w_hv[k] || w_src[k] == '0) begin
        w_opr_v[k] = '0;
      end else if (k >= 2 && w_ren[0] && w_rd[0] == w_src[k]) begin
        w_opr_q[k] = bus.iss_tag[0 +: TAGW];
      end else if (r_busy[w_src[k]] && bus.cmt_valid &&
                   bus.cmt_tag == r_tag[w_src[k]]) begin
        w_opr_v[k] = bus.cmt_val;
      end else if (r_busy[w_src[k]] && bus.rob_q_rdy[k]) begin
        w_opr_v[k] = bus.rob_q_val[k*XLEN +: XLEN];
      end else if (r_busy[w_src[k]]) begin
        w_opr_q[k] = r_tag[w_src[k]];
      end else begin
        w_opr_v[k] = r_data[w_src[k]];
      end
    end
  end

  // Next busy/tag state. Commit clear is applied before issue so a
  // same-cycle rename of cmt_rd overrides it; slot1 overrides slot0.
  always_comb begin
    w_busy_nxt = r_busy;
    w_tag_nxt  = r_tag;
    if (bus.flush) begin
      w_busy_nxt = '0;
      w_tag_nxt  = '0;
    end else begin
      if (bus.cmt_valid && bus.cmt_rd != '0 && r_tag[bus.cmt_rd] == bus.cmt_tag) begin
        w_busy_nxt[bus.cmt_rd] = 1'b0;
        w_tag_nxt[bus.cmt_rd]  = '0;
      end
      for (int s = 0; s < 2; s++) begin
        if (w_ren[s]) begin
          w_busy_nxt[w_rd[s]] = 1'b1;
          w_tag_nxt[w_rd[s]]  = bus.iss_tag[s*TAGW +: TAGW];
        end
      end
    end
    w_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      w_cnt_nxt = w_cnt_nxt + (REG_LOG+1)'(w_busy_nxt[i]);
  end

  // State update; everything holds while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_busy     <= '0;
      r_tag      <= '0;
      r_busy_cnt <= '0;
    end else if (bus.rdy) begin
      r_busy     <= w_busy_nxt;
      r_tag      <= w_tag_nxt;
      r_busy_cnt <= w_cnt_nxt;
      if (bus.cmt_valid && bus.cmt_rd != '0)
        r_data[bus.cmt_rd] <= bus.cmt_val;
    end
  end
endmodule

// File: tb/tb_regfile_rename2.sv
// Randomized + directed bench for regfile_rename2 against a behavioural model.
module tb_regfile_rename2;
  logic clk, rst;
  int   n_err = 0, n_chk = 0;

  regfile_rename2_if #(.XLEN(32), .REG_LOG(5), .ROB_LOG(3)) bus();
  regfile_rename2 #(.XLEN(32), .REG_LOG(5), .ROB_LOG(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_data [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int src_of(input int k);
    int s = k / 2;
    return (k % 2 == 0) ? int'(bus.iss_rs1[s*5 +: 5]) : int'(bus.iss_rs2[s*5 +: 5]);
  endfunction

  function automatic void exp_op(input int k, output logic [31:0] v, output logic [3:0] q);
    int s = k / 2;
    int src = src_of(k);
    logic hv = (k % 2 == 0) ? bus.iss_rs1_hv[s] : bus.iss_rs2_hv[s];
    int rd0 = int'(bus.iss_rd[4:0]);
    v = 0; q = 0;
    if (!bus.iss_valid[s] || !hv || src == 0) return;
    if (s == 1 && bus.iss_valid[0] && bus.iss_rd_hv[0] && rd0 != 0 && rd0 == src)
      q = bus.iss_tag[3:0];
    else if (m_busy[src] && bus.cmt_valid && bus.cmt_tag == m_tag[src]) v = bus.cmt_val;
    else if (m_busy[src] && bus.rob_q_rdy[k]) v = bus.rob_q_val[k*32 +: 32];
    else if (m_busy[src]) q = m_tag[src];
    else v = m_data[src];
  endfunction

  task automatic check_all();
    logic [31:0] v; logic [3:0] q;
    for (int k = 0; k < 4; k++) begin
      exp_op(k, v, q);
      chk($sformatf("opr_v%0d", k), 64'(bus.opr_v[k*32 +: 32]), 64'(v));
      chk($sformatf("opr_q%0d", k), 64'(bus.opr_q[k*4 +: 4]), 64'(q));
      chk($sformatf("rob_q_tag%0d", k), 64'(bus.rob_q_tag[k*4 +: 4]), 64'(m_tag[src_of(k)]));
    end
    chk("busy_cnt", 64'(bus.busy_cnt), 64'(m_cnt));
  endtask

  // apply one clock edge of the architectural rules to the model
  task automatic model_step();
    bit renamed [32];
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_data[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
      m_cnt = 0;
      return;
    end
    if (!bus.rdy) return;
    if (bus.cmt_valid && bus.cmt_rd != 0) m_data[bus.cmt_rd] = bus.cmt_val;
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
    end else begin
      for (int i = 0; i < 32; i++) renamed[i] = 0;
      for (int s = 0; s < 2; s++)
        if (bus.iss_valid[s] && bus.iss_rd_hv[s]) renamed[bus.iss_rd[s*5 +: 5]] = 1;
      if (bus.cmt_valid && bus.cmt_rd != 0 && m_tag[bus.cmt_rd] == bus.cmt_tag &&
          !renamed[bus.cmt_rd]) begin
        m_busy[bus.cmt_rd] = 0; m_tag[bus.cmt_rd] = 0;
      end
      for (int s = 0; s < 2; s++) begin
        int rd = int'(bus.iss_rd[s*5 +: 5]);
        if (bus.iss_valid[s] && bus.iss_rd_hv[s] && rd != 0) begin
          m_busy[rd] = 1; m_tag[rd] = bus.iss_tag[s*4 +: 4];
        end
      end
    end
    m_cnt = 0;
    for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
  endtask

  task automatic idle();
    rst = 0;
    bus.rdy = 1; bus.flush = 0;
    bus.iss_valid = 0; bus.iss_rs1_hv = 0; bus.iss_rs2_hv = 0; bus.iss_rd_hv = 0;
    bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rd = 0; bus.iss_tag = 0;
    bus.rob_q_rdy = 0; bus.rob_q_val = 0;
    bus.cmt_valid = 0; bus.cmt_rd = 0; bus.cmt_tag = 0; bus.cmt_val = 0;
  endtask

  task automatic tick(input bit do_chk = 1);
    #1;
    if (do_chk) check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic issue(input int s, input int rd, input int tag);
    bus.iss_valid[s] = 1; bus.iss_rd_hv[s] = 1;
    bus.iss_rd[s*5 +: 5] = 5'(rd); bus.iss_tag[s*4 +: 4] = 4'(tag);
  endtask

  task automatic read0(input int rs1, input int rs2);
    bus.iss_valid[0] = 1; bus.iss_rs1_hv[0] = 1; bus.iss_rs2_hv[0] = 1;
    bus.iss_rs1[4:0] = 5'(rs1); bus.iss_rs2[4:0] = 5'(rs2);
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    model_step();
    tick(0);
    // reset state and basic read
    idle(); read0(5, 0); #1;
    chk("rst_v", 64'(bus.opr_v[63:0]), 64'h0);
    chk("rst_q", 64'(bus.opr_q[7:0]), 64'h0);
    chk("rst_cnt", 64'(bus.busy_cnt), 64'h0);
    tick();
    // intra-group bypass then busy lookup
    idle(); issue(0, 3, 2);
    bus.iss_valid[1] = 1; bus.iss_rs1_hv[1] = 1; bus.iss_rs1[9:5] = 5'd3; #1;
    chk("byp_q", 64'(bus.opr_q[11:8]), 64'h2);
    tick();
    idle(); read0(3, 0); #1;
    chk("x3_q", 64'(bus.opr_q[3:0]), 64'h2);
    chk("cnt_1", 64'(bus.busy_cnt), 64'h1);
    tick();
    // commit forwarding
    idle(); read0(3, 0);
    bus.cmt_valid = 1; bus.cmt_rd = 3; bus.cmt_tag = 2; bus.cmt_val = 32'hDEAD_BEEF; #1;
    chk("cmt_fwd_v", 64'(bus.opr_v[31:0]), 64'hDEAD_BEEF);
    chk("cmt_fwd_q", 64'(bus.opr_q[3:0]), 64'h0);
    tick();
    idle(); read0(3, 0); #1;
    chk("x3_data", 64'(bus.opr_v[31:0]), 64'hDEAD_BEEF);
    chk("cnt_0", 64'(bus.busy_cnt), 64'h0);
    tick();
    // same rd in both slots, stale commit
    idle(); issue(0, 7, 4); issue(1, 7, 5); tick();
    idle(); bus.cmt_valid = 1; bus.cmt_rd = 7; bus.cmt_tag = 4; bus.cmt_val = 32'h1234; tick();
    idle(); read0(7, 0); #1;
    chk("x7_q", 64'(bus.opr_q[3:0]), 64'h5);
    chk("cnt_x7", 64'(bus.busy_cnt), 64'h1);
    tick();
    // flush with commit
    idle(); issue(0, 9, 6); issue(1, 10, 7); tick();
    idle(); issue(0, 11, 8); tick();
    idle(); bus.flush = 1; issue(0, 12, 9);
    bus.cmt_valid = 1; bus.cmt_rd = 9; bus.cmt_tag = 1; bus.cmt_val = 32'h10; tick();
    idle(); read0(9, 12); #1;
    chk("flush_cnt", 64'(bus.busy_cnt), 64'h0);
    chk("x9_v", 64'(bus.opr_v[31:0]), 64'h10);
    chk("x12_q", 64'(bus.opr_q[7:4]), 64'h0);
    tick();
    // rdy low freezes state
    idle(); bus.rdy = 0; issue(0, 12, 3);
    bus.cmt_valid = 1; bus.cmt_rd = 9; bus.cmt_tag = 0; bus.cmt_val = 32'h55; tick();
    idle(); read0(9, 12); #1;
    chk("frz_v", 64'(bus.opr_v[31:0]), 64'h10);
    chk("frz_q", 64'(bus.opr_q[7:4]), 64'h0);
    chk("frz_cnt", 64'(bus.busy_cnt), 64'h0);
    tick();
    idle(); issue(0, 12, 3); tick();
    idle(); read0(12, 0); #1;
    chk("rdy_q", 64'(bus.opr_q[3:0]), 64'h3);
    chk("rdy_cnt", 64'(bus.busy_cnt), 64'h1);
    tick();
    // random traffic on a small register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst       = ($urandom_range(0, 99) == 0);
      bus.rdy   = ($urandom_range(0, 7) != 0);
      bus.flush = ($urandom_range(0, 29) == 0);
      bus.iss_valid  = 2'($urandom); bus.iss_rs1_hv = 2'($urandom);
      bus.iss_rs2_hv = 2'($urandom); bus.iss_rd_hv  = 2'($urandom);
      for (int s = 0; s < 2; s++) begin
        bus.iss_rs1[s*5 +: 5] = 5'($urandom_range(0, 7));
        bus.iss_rs2[s*5 +: 5] = 5'($urandom_range(0, 7));
        bus.iss_rd[s*5 +: 5]  = 5'($urandom_range(0, 7));
        bus.iss_tag[s*4 +: 4] = 4'($urandom_range(1, 15));
      end
      bus.rob_q_rdy = 4'($urandom);
      bus.rob_q_val = {$urandom, $urandom, $urandom, $urandom};
      bus.cmt_valid = $urandom_range(0, 1) == 1;
      bus.cmt_rd    = 5'($urandom_range(0, 7));
      bus.cmt_tag   = ($urandom_range(0, 1) == 1) ? m_tag[bus.cmt_rd] : 4'($urandom_range(1, 15));
      bus.cmt_val   = $urandom;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
